fpu_sequencer: RTL and testbench

Multi-cycle issue controller for the floating-point ALU. It sits between the instruction decoder's FP control outputs and the FP ALU/FP register file. It accepts one FP operation at a time and launches it on the ALU. It counts the operation's fixed latency, then produces a one-cycle FP register write-back. While an operation is in flight it stalls any further FP issue; integer instructions are not stalled.

---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fpu_sequencer_if.sv | 30 +++
 rtl/fpu_sequencer.sv | 100 ++++++++++
 tb/tb_fpu_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP op codes, sequencer state encoding and default execute latencies.
// Imported by the decoder, the FP ALU and the sequencer.
package fpu_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned DST_W = 2;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_MUL  = 3'd1;
  localparam logic [OP_W-1:0] OP_DIV  = 3'd2;
  localparam logic [OP_W-1:0] OP_SQRT = 3'd3;

  localparam int unsigned DEF_LAT_ADD  = 2;
  localparam int unsigned DEF_LAT_MUL  = 3;
  localparam int unsigned DEF_LAT_DIV  = 8;
  localparam int unsigned DEF_LAT_SQRT = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Operation captured at issue and held until write-back
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic             src_imm;
    logic [REG_W-1:0] addr;
  } fpu_cmd_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op, input logic [DST_W-1:0] dst);
    return (op <= OP_SQRT) && (dst <= 2'd1);
  endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// Decoder-side issue fields and ALU / register-file side control of the FP sequencer.
interface fpu_sequencer_if;

  logic                          issue_valid;
  logic [fpu_pkg::OP_W-1:0]      fp_alu_cntrl;
  logic [fpu_pkg::DST_W-1:0]     fp_reg_dst;
  logic                          fp_alu_src;
  logic [fpu_pkg::REG_W-1:0]     Rt;
  logic [fpu_pkg::REG_W-1:0]     Rd;

  logic                          fpu_start;
  logic [fpu_pkg::OP_W-1:0]      fpu_op;
  logic                          fpu_src_imm;
  logic                          stall;
  logic                          busy;
  logic                          wb_en;
  logic [fpu_pkg::REG_W-1:0]     wb_addr;
  logic                          illegal;

  modport master (
    output issue_valid, fp_alu_cntrl, fp_reg_dst, fp_alu_src, Rt, Rd,
    input  fpu_start, fpu_op, fpu_src_imm, stall, busy, wb_en, wb_addr, illegal
  );

  modport slave (
    input  issue_valid, fp_alu_cntrl, fp_reg_dst, fp_alu_src, Rt, Rd,
    output fpu_start, fpu_op, fpu_src_imm, stall, busy, wb_en, wb_addr, illegal
  );

endinterface

// File: rtl/fpu_sequencer.sv
// Single-issue FP sequencer: launches one op, counts its fixed latency, then
// raises a one-cycle write-back. Further FP issue is stalled while executing.
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADD  = DEF_LAT_ADD,
  parameter int unsigned LAT_MUL  = DEF_LAT_MUL,
  parameter int unsigned LAT_DIV  = DEF_LAT_DIV,
  parameter int unsigned LAT_SQRT = DEF_LAT_SQRT
) (
  input  logic            clk,
  input  logic            reset,
  fpu_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fpu_cmd_t         cmd_q, cmd_d;
  logic             start_q, start_d;
  logic             wb_q, wb_d;
  logic             illegal_q, illegal_d;
  logic             busy_q;
  logic             legal;

  function automatic logic [CNT_W-1:0] lat_of(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD:  lat_of = CNT_W'(LAT_ADD);
      OP_MUL:  lat_of = CNT_W'(LAT_MUL);
      OP_DIV:  lat_of = CNT_W'(LAT_DIV);
      OP_SQRT: lat_of = CNT_W'(LAT_SQRT);
      default: lat_of = '0;
    endcase
  endfunction

  assign legal = is_legal(bus.fp_alu_cntrl, bus.fp_reg_dst);

  // Next-state, counter and pulse generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    start_d   = 1'b0;
    wb_d      = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_WB: begin
        state_d = ST_IDLE;
        if (bus.issue_valid && legal) begin
          state_d       = ST_EXEC;
          cnt_d         = lat_of(bus.fp_alu_cntrl);
          cmd_d.op      = bus.fp_alu_cntrl;
          cmd_d.src_imm = bus.fp_alu_src;
          cmd_d.addr    = (bus.fp_reg_dst == 2'd1) ? bus.Rd : bus.Rt;
          start_d       = 1'b1;
        end else if (bus.issue_valid) begin
          illegal_d = 1'b1;
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_WB;
          wb_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      start_q   <= 1'b0;
      wb_q      <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      start_q   <= start_d;
      wb_q      <= wb_d;
      illegal_q <= illegal_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign bus.fpu_start   = start_q;
  assign bus.fpu_op      = cmd_q.op;
  assign bus.fpu_src_imm = cmd_q.src_imm;
  assign bus.wb_addr     = cmd_q.addr;
  assign bus.wb_en       = wb_q;
  assign bus.illegal     = illegal_q;
  assign bus.busy        = busy_q;
  // Only the executing window blocks a new FP issue; WB accepts back-to-back
  assign bus.stall       = bus.issue_valid && (state_q == ST_EXEC);

endmodule

// File: tb/tb_fpu_sequencer.sv
// Bench for fpu_sequencer: directed vector table, multi-cycle corner sequences
// and random traffic checked against a timeline model of issue/exec/write-back.
module tb_fpu_sequencer;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_sequencer_if bus();

  fpu_sequencer #(
    .LAT_ADD (2),
    .LAT_MUL (3),
    .LAT_DIV (8),
    .LAT_SQRT(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [13:0] obs;
  assign obs = {bus.fpu_start, bus.fpu_op, bus.fpu_src_imm, bus.stall, bus.busy,
                bus.wb_en, bus.wb_addr, bus.illegal};

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct packed {
    logic        iv;
    logic [2:0]  op;
    logic [1:0]  dst;
    logic        src;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [13:0] ex(input int st, input int op, input int imm, input int stl,
                                     input int bsy, input int wb, input int addr, input int ill);
    return {1'(st), 3'(op), 1'(imm), 1'(stl), 1'(bsy), 1'(wb), 5'(addr), 1'(ill)};
  endfunction

  function automatic vec_t mk(input int iv, input int op, input int dst, input int src,
                              input int rt, input int rd, input logic [13:0] e);
    vec_t v;
    v.iv = 1'(iv); v.op = 3'(op); v.dst = 2'(dst); v.src = 1'(src);
    v.rt = 5'(rt); v.rd = 5'(rd); v.exp = e;
    return v;
  endfunction

  function automatic int lat_of(input int op);
    case (op)
      0: return 2;
      1: return 3;
      2: return 8;
      default: return 10;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input int rst, input int iv, input int op, input int dst,
                       input int src, input int rt, input int rd);
    reset            = 1'(rst);
    bus.issue_valid  = 1'(iv);
    bus.fp_alu_cntrl = 3'(op);
    bus.fp_reg_dst   = 2'(dst);
    bus.fp_alu_src   = 1'(src);
    bus.Rt           = 5'(rt);
    bus.Rd           = 5'(rd);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  int acc_c, acc_lat, bad_c;
  logic [2:0]  m_op;
  logic        m_imm;
  logic [4:0]  m_addr;
  logic [13:0] pred;
  logic        in_exec;
  int r_rst, r_iv, r_op, r_dst, r_src, r_rt, r_rd;

  initial begin
    // Reset values
    do_reset();
    @(negedge clk);
    chk("reset", 32'(obs), 32'(0));
    next_cycle();

    // Directed table: add Rd=5 (+stall probe), illegal op/dst, mul-imm Rt=7, add in WB
    vecs.push_back(mk(1, 0, 1, 0, 9, 5,  ex(0, 0, 0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(1, 0, 0, 0, 1, 0, 5, 0)));
    vecs.push_back(mk(1, 3, 1, 0, 0, 1,  ex(0, 0, 0, 1, 1, 0, 5, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(0, 0, 0, 0, 1, 1, 5, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(0, 0, 0, 0, 0, 0, 5, 0)));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0,  ex(0, 0, 0, 0, 0, 0, 5, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(0, 0, 0, 0, 0, 0, 5, 1)));
    vecs.push_back(mk(1, 0, 2, 0, 0, 0,  ex(0, 0, 0, 0, 0, 0, 5, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(0, 0, 0, 0, 0, 0, 5, 1)));
    vecs.push_back(mk(1, 1, 0, 1, 7, 3,  ex(0, 0, 0, 0, 0, 0, 5, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(1, 1, 1, 0, 1, 0, 7, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(0, 1, 1, 0, 1, 0, 7, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(0, 1, 1, 0, 1, 0, 7, 0)));
    vecs.push_back(mk(1, 0, 1, 0, 4, 12, ex(0, 1, 1, 0, 1, 1, 7, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(1, 0, 0, 0, 1, 0, 12, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(0, 0, 0, 0, 1, 0, 12, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(0, 0, 0, 0, 1, 1, 12, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  ex(0, 0, 0, 0, 0, 0, 12, 0)));
    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, int'(vecs[i].iv), int'(vecs[i].op), int'(vecs[i].dst), int'(vecs[i].src),
            int'(vecs[i].rt), int'(vecs[i].rd));
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
      next_cycle();
    end

    // div.s Rd=10 at cycle 0, add.s Rd=11 held from cycle 2 until accepted in WB
    do_reset();
    for (int c = 0; c < 14; c++) begin
      drive(0, int'(c == 0 || (c >= 2 && c <= 9)), (c == 0) ? 2 : 0, 1, 0, 0, (c == 0) ? 10 : 11);
      @(negedge clk);
      chk("div_stall", 32'(bus.stall), 32'(c >= 2 && c <= 8));
      chk("div_start", 32'(bus.fpu_start), 32'(c == 1 || c == 10));
      chk("div_wb", 32'(bus.wb_en), 32'(c == 9 || c == 12));
      if (c == 9)  chk("div_wb_addr", 32'(bus.wb_addr), 32'(10));
      if (c == 12) chk("add_wb_addr", 32'(bus.wb_addr), 32'(11));
      next_cycle();
    end

    // sqrt.s Rd=20 at cycle 0, reset in cycle 4 drops it
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(int'(c == 4), int'(c == 0), 3, 1, 0, 0, 20);
      @(negedge clk);
      chk("sqrt_wb", 32'(bus.wb_en), 32'(0));
      if (c == 3) chk("sqrt_busy", 32'(bus.busy), 32'(1));
      if (c == 5) chk("sqrt_reset", 32'(obs), 32'(0));
      next_cycle();
    end

    // Random traffic against the issue-timeline model
    do_reset();
    acc_c = -1000; acc_lat = 0; bad_c = -1000;
    m_op = '0; m_imm = 1'b0; m_addr = '0;
    for (int i = 0; i < 700; i++) begin
      r_rst = ($urandom_range(0, 49) == 0) ? 1 : 0;
      r_iv  = int'($urandom_range(0, 1));
      r_op  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 7));
      r_dst = ($urandom_range(0, 5) != 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      r_src = int'($urandom_range(0, 1));
      r_rt  = int'($urandom_range(0, 31));
      r_rd  = int'($urandom_range(0, 31));
      drive(r_rst, r_iv, r_op, r_dst, r_src, r_rt, r_rd);
      @(negedge clk);
      in_exec = (cyc > acc_c) && (cyc <= acc_c + acc_lat);
      pred = ex(int'(cyc == acc_c + 1), int'(m_op), int'(m_imm), int'(r_iv != 0 && in_exec),
                int'(cyc > acc_c && cyc <= acc_c + acc_lat + 1), int'(cyc == acc_c + acc_lat + 1),
                int'(m_addr), int'(cyc == bad_c + 1));
      chk("rand", 32'(obs), 32'(pred));
      if (r_rst != 0) begin
        acc_c = -1000; acc_lat = 0; bad_c = -1000;
        m_op = '0; m_imm = 1'b0; m_addr = '0;
      end else if (r_iv != 0 && !in_exec) begin
        if (r_op <= 3 && r_dst <= 1) begin
          acc_c   = cyc;
          acc_lat = lat_of(r_op);
          m_op    = 3'(r_op);
          m_imm   = 1'(r_src);
          m_addr  = 5'((r_dst == 1) ? r_rd : r_rt);
        end else begin
          bad_c = cyc;
        end
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
